// File: rtl/led_pkg.sv
// led_pkg: shared encodings for the LED pattern engine.
//   mode_e  - step behaviour selected by the 2-bit mode input
//   dir_e   - bounce travel direction (LEFT = towards the MSB)
//   MODE_W  - width of the mode input
package led_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_ROT_R  = 2'd0,
    MODE_ROT_L  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: programmable prescaler producing the pattern step strobe.
// One step every div_val+1 enabled cycles; div_val = 0 steps every cycle.
//   clk_in  - system clock (rising edge)
//   rst     - synchronous active-high reset (cnt = 0, div_val = DIV_DEFAULT)
//   en      - 1: count; 0: hold cnt, no step
//   div_ld  - load div_in into div_val, clear cnt, suppress step
//   div_in  - new divider value
//   restart - pattern load: clear cnt, suppress step
//   step    - combinational strobe, high in the cycle the pattern advances
module led_tick_gen #(
  parameter int unsigned DIV_W       = 25,
  parameter int unsigned DIV_DEFAULT = 24_000_000
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             div_ld,
  input  logic [DIV_W-1:0] div_in,
  input  logic             restart,
  output logic             step
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    step  = 1'b0;
    if (div_ld) div_d = div_in;
    // Either load restarts the period and swallows a coincident terminal count.
    if (div_ld || restart) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == div_q) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= DIV_W'(DIV_DEFAULT);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: N-channel LED pattern generator.
// On each prescaler step the internal active-high pattern rotates right,
// rotates left, bounces (zero-fill shift, reversing at the ends) or inverts.
// Optional build macro LED_PWM_EN adds PWM_W / duty brightness gating.
//   clk_in   - system clock (rising edge)
//   rst      - synchronous active-high reset
//   en       - 1: run; 0: freeze prescaler and pattern
//   mode     - 0 ROT_R, 1 ROT_L, 2 BOUNCE, 3 BLINK
//   pat_ld   - load pat_in (wins over a step, clears prescaler)
//   pat_in   - new active-high pattern
//   div_ld   - load div_in as divider (clears prescaler, no step)
//   div_in   - new divider value
//   tick_out - registered pulse, high in the cycle the pattern changes
//   led_out  - registered LED drive, one cycle behind the pattern
//   duty     - (LED_PWM_EN only) lit channels on while pwm_cnt < duty
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int unsigned      N_LED       = 8,
  parameter int unsigned      DIV_W       = 25,
  parameter int unsigned      DIV_DEFAULT = 24_000_000,
  parameter logic [N_LED-1:0] INIT_PAT    = N_LED'(1),
  parameter bit               ACTIVE_LOW  = 1'b1
`ifdef LED_PWM_EN
  ,
  parameter int unsigned      PWM_W       = 4
`endif
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              pat_ld,
  input  logic [N_LED-1:0]  pat_in,
  input  logic              div_ld,
  input  logic [DIV_W-1:0]  div_in,
  output logic              tick_out,
  output logic [N_LED-1:0]  led_out
`ifdef LED_PWM_EN
  ,
  input  logic [PWM_W-1:0]  duty
`endif
);

  localparam logic [N_LED-1:0] LED_MASK = {N_LED{ACTIVE_LOW}};

  logic             step;
  logic [N_LED-1:0] pat_q, pat_d;
  dir_e             dir_q, dir_d;
  logic             tick_q;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_LED-1:0] shl, shr;

  led_tick_gen #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_tick_gen (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .div_ld  (div_ld),
    .div_in  (div_in),
    .restart (pat_ld),
    .step    (step)
  );

  assign shl = {pat_q[N_LED-2:0], 1'b0};
  assign shr = {1'b0, pat_q[N_LED-1:1]};

  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    if (pat_ld) begin
      pat_d = pat_in;
    end else if (step) begin
      case (mode_e'(mode))
        MODE_ROT_R: pat_d = {pat_q[0], pat_q[N_LED-1:1]};
        MODE_ROT_L: pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
        MODE_BOUNCE: begin
          // Reversal happens on the step that finds a lit end bit, and that
          // same step already moves in the new direction.
          if (dir_q == DIR_LEFT) begin
            if (pat_q[N_LED-1]) begin
              dir_d = DIR_RIGHT;
              pat_d = shr;
            end else begin
              pat_d = shl;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = DIR_LEFT;
              pat_d = shl;
            end else begin
              pat_d = shr;
            end
          end
        end
        MODE_BLINK: pat_d = ~pat_q;
        default:    pat_d = pat_q;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;
  logic             pwm_on;

  assign pwm_on = (pwm_cnt_q < duty);
  assign led_d  = (pat_q & {N_LED{pwm_on}}) ^ LED_MASK;

  always_ff @(posedge clk_in) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
  end
`else
  assign led_d = pat_q ^ LED_MASK;
`endif

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pat_q  <= INIT_PAT;
      dir_q  <= DIR_LEFT;
      tick_q <= 1'b0;
      led_q  <= INIT_PAT ^ LED_MASK;
    end else begin
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      tick_q <= step;
      led_q  <= led_d;
    end
  end

  assign tick_out = tick_q;
  assign led_out  = led_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine (N_LED=8, DIV_DEFAULT=3).
// Directed table and sequences with hand-derived values, then randomized
// stimulus compared every cycle against a behavioural model.
module tb_led_pattern_engine;

  logic       clk_in = 1'b0;
  logic       rst, en, pat_ld, div_ld;
  logic [1:0] mode;
  logic [7:0] pat_in, div_in;
  logic       tick_out;
  logic [7:0] led_out;
`ifdef LED_PWM_EN
  logic [3:0] duty;
`endif

  led_pattern_engine #(
    .N_LED       (8),
    .DIV_W       (8),
    .DIV_DEFAULT (3),
    .INIT_PAT    (8'h01),
    .ACTIVE_LOW  (1'b1)
`ifdef LED_PWM_EN
    ,
    .PWM_W       (4)
`endif
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .pat_ld   (pat_ld),
    .pat_in   (pat_in),
    .div_ld   (div_ld),
    .div_in   (div_in),
    .tick_out (tick_out),
    .led_out  (led_out)
`ifdef LED_PWM_EN
    ,
    .duty     (duty)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state (plain integers, pattern held as 0..255).
  int m_pat, m_cnt, m_div, m_tick, m_led, m_pwm, m_pwm_prev;
  bit m_right;

  task automatic chk(input string name, input logic [31:0] got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
    end
  endtask

  // LED level expected for an active-high pattern at the last edge.
  function automatic int gate(input int e);
`ifdef LED_PWM_EN
    return (m_pwm_prev < int'(duty)) ? e : 255;
`else
    return e;
`endif
  endfunction

  task automatic model_edge();
    int  led_new;
    bit  step;
    if (rst) begin
      m_pat = 1; m_right = 0; m_cnt = 0; m_div = 3;
      m_tick = 0; m_led = 254; m_pwm = 0; m_pwm_prev = 0;
    end else begin
      m_pwm_prev = m_pwm;
      led_new = m_pat ^ 255;
`ifdef LED_PWM_EN
      if (m_pwm >= int'(duty)) led_new = 255;
`endif
      step = en && !pat_ld && !div_ld && (m_cnt == m_div);
      if (pat_ld || div_ld) m_cnt = 0;
      else if (en)          m_cnt = (m_cnt == m_div) ? 0 : m_cnt + 1;
      if (div_ld) m_div = int'(div_in);
      if (pat_ld) begin
        m_pat = int'(pat_in);
      end else if (step) begin
        case (mode)
          2'd0: m_pat = (m_pat >> 1) | ((m_pat & 1) << 7);
          2'd1: m_pat = ((m_pat << 1) & 255) | (m_pat >> 7);
          2'd2: begin
            if (!m_right) begin
              if (m_pat >= 128) begin m_right = 1; m_pat = m_pat / 2; end
              else m_pat = (m_pat * 2) % 256;
            end else begin
              if (m_pat % 2 == 1) begin m_right = 0; m_pat = (m_pat * 2) % 256; end
              else m_pat = m_pat / 2;
            end
          end
          default: m_pat = m_pat ^ 255;
        endcase
      end
      m_tick = step ? 1 : 0;
      m_led  = led_new;
      m_pwm  = (m_pwm + 1) % 16;
    end
  endtask

  // One clock: model follows the edge, outputs checked at the falling edge.
  task automatic cyc();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    chk("mdl_tick", 32'(tick_out), m_tick);
    chk("mdl_led", 32'(led_out), m_led);
  endtask

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       exp_tick;
    logic [7:0] exp_led;
  } vec_t;

  vec_t  tbl[13];
  int    bnc[10];
  int    lit;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; pat_ld = 1'b0; pat_in = '0;
    div_ld = 1'b0; div_in = '0;
`ifdef LED_PWM_EN
    duty = 4'd15;
`endif
    @(negedge clk_in);
    cyc();
    cyc();
    chk("rst_tick", 32'(tick_out), 0);
    chk("rst_led", 32'(led_out), gate(8'hFE));
    rst = 1'b0;

    // ROT_R from 01 with divider 3: step every 4th edge, LED one cycle later.
    tbl = '{
      '{1'b1, 2'd0, 1'b0, 8'hFE}, '{1'b1, 2'd0, 1'b0, 8'hFE},
      '{1'b1, 2'd0, 1'b0, 8'hFE}, '{1'b1, 2'd0, 1'b1, 8'hFE},
      '{1'b1, 2'd0, 1'b0, 8'h7F}, '{1'b1, 2'd0, 1'b0, 8'h7F},
      '{1'b1, 2'd0, 1'b0, 8'h7F}, '{1'b1, 2'd0, 1'b1, 8'h7F},
      '{1'b1, 2'd0, 1'b0, 8'hBF}, '{1'b1, 2'd0, 1'b0, 8'hBF},
      '{1'b1, 2'd0, 1'b0, 8'hBF}, '{1'b1, 2'd0, 1'b1, 8'hBF},
      '{1'b1, 2'd0, 1'b0, 8'hDF}
    };
    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en; mode = tbl[i].mode;
      cyc();
      chk("tbl_tick", 32'(tick_out), int'(tbl[i].exp_tick));
      chk("tbl_led", 32'(led_out), gate(int'(tbl[i].exp_led)));
    end

    // BOUNCE from 40 moving left, divider 0: reversal at bit 7 and bit 0.
    en = 1'b0; mode = 2'd2; pat_ld = 1'b1; pat_in = 8'h40; div_ld = 1'b1; div_in = 8'd0;
    cyc();
    pat_ld = 1'b0; div_ld = 1'b0; en = 1'b1;
    bnc = '{8'hBF, 8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFD};
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bnc_tick", 32'(tick_out), 1);
      chk("bnc_led", 32'(led_out), gate(bnc[i]));
    end

    // BLINK: load A5 swallows the coincident step, then toggles each step.
    mode = 2'd3; pat_ld = 1'b1; pat_in = 8'hA5;
    cyc();
    chk("pld_discard", 32'(tick_out), 0);
    pat_ld = 1'b0;
    cyc(); chk("blk_led0", 32'(led_out), gate(8'h5A));
    cyc(); chk("blk_led1", 32'(led_out), gate(8'hA5));
    cyc(); chk("blk_led2", 32'(led_out), gate(8'h5A));

    // Freeze with cnt = 2 of 3: no ticks, then the period resumes where it left.
    div_ld = 1'b1; div_in = 8'd3;
    cyc(); chk("dld_suppress", 32'(tick_out), 0);
    div_ld = 1'b0;
    cyc(); cyc();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("frz_tick", 32'(tick_out), 0);
      chk("frz_led", 32'(led_out), gate(8'hA5));
    end
    en = 1'b1;
    cyc(); chk("frz_resume0", 32'(tick_out), 0);
    cyc(); chk("frz_resume1", 32'(tick_out), 1);
    cyc(); chk("frz_led_after", 32'(led_out), gate(8'h5A));

    // div_ld to 0 exactly when cnt == div_val: no tick, then every cycle.
    cyc(); cyc();
    div_ld = 1'b1; div_in = 8'd0;
    cyc(); chk("dld_coinc", 32'(tick_out), 0);
    div_ld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("dld_every", 32'(tick_out), 1);
    end

    // pat_ld coincident with a step: next tick div_val+1 cycles later.
    div_ld = 1'b1; div_in = 8'd3;
    cyc();
    div_ld = 1'b0;
    cyc(); cyc(); cyc();
    mode = 2'd0; pat_ld = 1'b1; pat_in = 8'h3C;
    cyc(); chk("pld_coinc", 32'(tick_out), 0);
    pat_ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("pld_next_tick", 32'(tick_out), (i == 3) ? 1 : 0);
      if (i == 0) chk("pld_latency", 32'(led_out), gate(8'hC3));
    end

    // Reset while bouncing right with a partial count.
    mode = 2'd2; pat_ld = 1'b1; pat_in = 8'h80;
    cyc();
    pat_ld = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_tick", 32'(tick_out), 0);
    chk("rst_mid_led", 32'(led_out), gate(8'hFE));
    rst = 1'b0; en = 1'b0; pat_ld = 1'b1; pat_in = 8'h10;
    cyc();
    pat_ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("rst_div_default", 32'(tick_out), (i == 3) ? 1 : 0);
    end
    cyc(); chk("rst_dir_left", 32'(led_out), gate(8'hDF));

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      en     = ($urandom_range(0, 9) != 0);
      mode   = 2'($urandom_range(0, 3));
      pat_ld = ($urandom_range(0, 19) == 0);
      pat_in = 8'($urandom);
      div_ld = ($urandom_range(0, 29) == 0);
      div_in = 8'($urandom_range(0, 4));
`ifdef LED_PWM_EN
      if ($urandom_range(0, 49) == 0) duty = 4'($urandom);
`endif
      cyc();
    end
    rst = 1'b0; pat_ld = 1'b0; div_ld = 1'b0;

`ifdef LED_PWM_EN
    // Duty 4 of 16: channel 0 of pattern 01 lit (low) for 4 cycles out of 16.
    duty = 4'd4; en = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (led_out[0] == 1'b0) lit++;
    end
    chk("pwm_duty", 32'(lit), 4);
`else
    lit = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
